// File: rtl/add_mul_div_control_pkg.sv
// Shared definitions for the iterative add/multiply/divide engines.
// Holds the engine FSM encoding and the iteration-counter width helper.
package add_mul_div_control_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    // Counter must reach WIDTH itself, one past the last iteration index.
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int DEFAULT_CNT_W = cnt_w(DEFAULT_WIDTH);

endpackage

// File: rtl/add_mul_div_control_add.sv
// Bit-serial LSB-first ripple adder engine.
// One sum bit per clock through a 1-bit carry register.
module addition_control
    import add_mul_div_control_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] add_out,
    output logic             final_carry,
    output logic             add_done
);

    localparam int CW = cnt_w(WIDTH);

    state_t state, next_state;
    logic [CW-1:0] count;
    logic [WIDTH-1:0] a, b, sum;
    logic carry, last, sbit, cbit;

    assign last = (count == CW'(WIDTH));
    assign sbit = a[0] ^ b[0] ^ carry;
    assign cbit = (a[0] & b[0]) | (carry & (a[0] ^ b[0]));
    assign add_done = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start) next_state = BUSY;
            BUSY:    if (last)  next_state = DONE;
            DONE:    if (start) next_state = BUSY;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count       <= '0;
            a           <= '0;
            b           <= '0;
            sum         <= '0;
            carry       <= 1'b0;
            add_out     <= '0;
            final_carry <= 1'b0;
        end else if (start && state != BUSY) begin
            count <= '0;
            a     <= in1;
            b     <= in2;
            sum   <= '0;
            carry <= 1'b0;
        end else if (state == BUSY) begin
            if (!last) begin
                sum   <= {sbit, sum[WIDTH-1:1]};
                carry <= cbit;
                a     <= a >> 1;
                b     <= b >> 1;
                count <= count + CW'(1);
            end else begin
                add_out     <= sum;
                final_carry <= carry;
            end
        end
    end

endmodule

// File: rtl/add_mul_div_control_div.sv
// Restoring shift-subtract divider engine, MSB-first.
// A zero divisor always subtracts, giving all-ones quotient and remainder = dividend.
module divider_control
    import add_mul_div_control_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_done
);

    localparam int CW = cnt_w(WIDTH);

    state_t state, next_state;
    logic [CW-1:0] count;
    logic [WIDTH-1:0] dvs, q, rem, nxt_rem;
    logic [WIDTH:0] trial;
    logic ge, last;

    assign last = (count == CW'(WIDTH));
    assign trial = {rem, q[WIDTH-1]};
    assign ge = (trial >= {1'b0, dvs});
    assign nxt_rem = ge ? WIDTH'(trial - {1'b0, dvs}) : trial[WIDTH-1:0];
    assign div_done = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start) next_state = BUSY;
            BUSY:    if (last)  next_state = DONE;
            DONE:    if (start) next_state = BUSY;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count     <= '0;
            dvs       <= '0;
            q         <= '0;
            rem       <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (start && state != BUSY) begin
            count <= '0;
            dvs   <= in2;
            q     <= in1;
            rem   <= '0;
        end else if (state == BUSY) begin
            if (!last) begin
                rem   <= nxt_rem;
                q     <= {q[WIDTH-2:0], ge};
                count <= count + CW'(1);
            end else begin
                quotient  <= q;
                remainder <= rem;
            end
        end
    end

endmodule

// File: rtl/add_mul_div_control_mul.sv
// Right-shift add-and-shift multiplier engine.
// Multiplier sits in the low half of the accumulator and shifts out LSB-first.
module multiplier_control
    import add_mul_div_control_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] mul_out_high,
    output logic [WIDTH-1:0] mul_out_low,
    output logic             mul_done
);

    localparam int CW = cnt_w(WIDTH);

    state_t state, next_state;
    logic [CW-1:0] count;
    logic [WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0] partial;
    logic last;

    assign last = (count == CW'(WIDTH));
    assign partial = {1'b0, acc[2*WIDTH-1:WIDTH]}
                   + (acc[0] ? {1'b0, mcand} : '0);
    assign mul_done = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start) next_state = BUSY;
            BUSY:    if (last)  next_state = DONE;
            DONE:    if (start) next_state = BUSY;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count        <= '0;
            mcand        <= '0;
            acc          <= '0;
            mul_out_high <= '0;
            mul_out_low  <= '0;
        end else if (start && state != BUSY) begin
            count <= '0;
            mcand <= in1;
            acc   <= {{WIDTH{1'b0}}, in2};
        end else if (state == BUSY) begin
            if (!last) begin
                acc   <= {partial, acc[WIDTH-1:1]};
                count <= count + CW'(1);
            end else begin
                mul_out_high <= acc[2*WIDTH-1:WIDTH];
                mul_out_low  <= acc[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/add_mul_div_control.sv
// Multi-cycle ADD/MUL/DIV datapath: three independent engines on shared clk/reset/start.
module add_mul_div_control
    import add_mul_div_control_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] add_in1,
    input  logic [WIDTH-1:0] add_in2,
    output logic [WIDTH-1:0] add_out,
    output logic             final_carry,
    output logic             add_done,
    input  logic [WIDTH-1:0] mul_in1,
    input  logic [WIDTH-1:0] mul_in2,
    output logic [WIDTH-1:0] mul_out_high,
    output logic [WIDTH-1:0] mul_out_low,
    output logic             mul_done,
    input  logic [WIDTH-1:0] div_in1,
    input  logic [WIDTH-1:0] div_in2,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_done
);

    addition_control #(.WIDTH(WIDTH)) u_add (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .in1         (add_in1),
        .in2         (add_in2),
        .add_out     (add_out),
        .final_carry (final_carry),
        .add_done    (add_done)
    );

    multiplier_control #(.WIDTH(WIDTH)) u_mul (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in1          (mul_in1),
        .in2          (mul_in2),
        .mul_out_high (mul_out_high),
        .mul_out_low  (mul_out_low),
        .mul_done     (mul_done)
    );

    divider_control #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in1       (div_in1),
        .in2       (div_in2),
        .quotient  (quotient),
        .remainder (remainder),
        .div_done  (div_done)
    );

endmodule

// File: tb/tb_add_mul_div_control.sv
// Directed plus randomized bench for add_mul_div_control against an arithmetic model.
module tb_add_mul_div_control;

    localparam int W = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [W-1:0] add_in1 = '0, add_in2 = '0;
    logic [W-1:0] mul_in1 = '0, mul_in2 = '0;
    logic [W-1:0] div_in1 = '0, div_in2 = '0;
    logic [W-1:0] add_out, mul_out_high, mul_out_low, quotient, remainder;
    logic final_carry, add_done, mul_done, div_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    add_mul_div_control #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .add_in1      (add_in1),
        .add_in2      (add_in2),
        .add_out      (add_out),
        .final_carry  (final_carry),
        .add_done     (add_done),
        .mul_in1      (mul_in1),
        .mul_in2      (mul_in2),
        .mul_out_high (mul_out_high),
        .mul_out_low  (mul_out_low),
        .mul_done     (mul_done),
        .div_in1      (div_in1),
        .div_in2      (div_in2),
        .quotient     (quotient),
        .remainder    (remainder),
        .div_done     (div_done)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " dones"}, 32'({add_done, mul_done, div_done}), 32'd0);
        check({tag, " add"}, 32'({final_carry, add_out}), 32'd0);
        check({tag, " mul"}, 32'({mul_out_high, mul_out_low}), 32'd0);
        check({tag, " div"}, 32'({quotient, remainder}), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic scramble();
        add_in1 = W'($urandom); add_in2 = W'($urandom);
        mul_in1 = W'($urandom); mul_in2 = W'($urandom);
        div_in1 = W'($urandom); div_in2 = W'($urandom);
    endtask

    // Launch all three engines, poke inputs during BUSY, check latency and results.
    task automatic run_op(input logic [W-1:0] a1, a2, m1, m2, d1, d2,
                          input bit busy_start, input bit full);
        int e_sum, e_prod, e_q, e_r;
        e_sum  = int'(a1) + int'(a2);
        e_prod = int'(m1) * int'(m2);
        e_q    = (d2 == 0) ? (1 << W) - 1 : int'(d1) / int'(d2);
        e_r    = (d2 == 0) ? int'(d1) : int'(d1) % int'(d2);
        add_in1 = a1; add_in2 = a2;
        mul_in1 = m1; mul_in2 = m2;
        div_in1 = d1; div_in2 = d2;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        scramble();
        for (int n = 1; n <= W + 1; n++) begin
            @(posedge clk);
            #1;
            if (busy_start && n == 3) start = 1'b0;
            if (full || n >= W)
                check($sformatf("done@%0d", n),
                      32'({add_done, mul_done, div_done}),
                      (n == W + 1) ? 32'h7 : 32'h0);
            if (busy_start && n == 2) begin
                scramble();
                start = 1'b1;
            end
        end
        check("add_out", 32'(add_out), 32'(e_sum % (1 << W)));
        check("carry", 32'(final_carry), 32'((e_sum >> W) & 1));
        check("mul", 32'({mul_out_high, mul_out_low}), 32'(e_prod));
        check("quot", 32'(quotient), 32'(e_q));
        check("rem", 32'(remainder), 32'(e_r));
        if (full) begin
            repeat (2) @(posedge clk);
            #1;
            check("hold done", 32'({add_done, mul_done, div_done}), 32'h7);
            check("hold add", 32'({final_carry, add_out}), 32'(e_sum));
            check("hold mul", 32'({mul_out_high, mul_out_low}),
                  32'(e_prod));
            check("hold div", 32'({quotient, remainder}),
                  32'((e_q << W) | e_r));
        end
    endtask

    initial begin
        #1;
        check_zero("reset async");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_zero("reset");

        run_op(4'd9, 4'd8, 4'd15, 4'd15, 4'd13, 4'd4, 1'b0, 1'b1);
        run_op(4'd15, 4'd15, 4'd3, 4'd5, 4'd15, 4'd1, 1'b0, 1'b1);
        run_op(4'd0, 4'd0, 4'd0, 4'd7, 4'd2, 4'd7, 1'b1, 1'b1);
        run_op(4'd6, 4'd3, 4'd2, 4'd9, 4'd9, 4'd0, 1'b0, 1'b1);
        run_op(4'd1, 4'd14, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1);

        for (int i = 0; i < 40; i++)
            run_op(W'($urandom), W'($urandom), W'($urandom),
                   W'($urandom), W'($urandom), W'($urandom),
                   1'($urandom), 1'b1);

        // Abort mid-operation: reset two edges after the start edge.
        scramble();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1 check_zero("abort");
        @(posedge clk);
        #1 reset = 1'b0;
        for (int n = 0; n < W + 3; n++) begin
            @(posedge clk);
            #1 check_zero($sformatf("abort idle %0d", n));
        end

        // start and reset together: reset wins.
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        start = 1'b0;
        repeat (W + 2) @(posedge clk);
        #1 check_zero("start+reset");

        run_op(4'd7, 4'd9, 4'd11, 4'd13, 4'd14, 4'd3, 1'b0, 1'b1);

        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 0; b < (1 << W); b++) begin
                do_reset();
                @(posedge clk);
                #1;
                run_op(W'(a), W'(b), W'(a), W'(b), W'(a), W'(b),
                       1'b0, 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
